// File: rtl/gamepad_pkg.sv
// Shared scan FSM state encoding, default 40 MHz timing constants and a
// small counter-width helper used by the gamepad scanner and its lanes.
package gamepad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PULSE_HI,
    PULSE_LO,
    COMMIT
  } scan_state_t;

  // 60 Hz poll period and 6 us half-phase at a 40 MHz system clock.
  localparam int DEFAULT_POLL_DIV = 666_666;
  localparam int DEFAULT_HALF_BIT = 240;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gamepad_lane.sv
// One pad lane: double-flop synchronizer on the raw serial line and a
// shadow register that stores each sampled bit inverted (line low = pressed).
module gamepad_lane
  import gamepad_pkg::*;
#(
  parameter int NUM_BUTTONS = 8,
  parameter int BIT_W       = width_of(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   data,
  input  logic                   sample,
  input  logic [BIT_W-1:0]       bit_idx,
  output logic [NUM_BUTTONS-1:0] shadow
);

  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      shadow <= '0;
    end else begin
      sync_1 <= data;
      sync_2 <= sync_1;
      if (sample) begin
        shadow[bit_idx] <= ~sync_2;
      end
    end
  end

endmodule

// File: rtl/gamepad_scanner.sv
// Polls NUM_PADS serial gamepads in parallel: latch strobe, shift pulses,
// per-bit sampling into lane shadows, then an atomic commit of all buttons.
module gamepad_scanner
  import gamepad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BUTTONS = 8,
  parameter int POLL_DIV    = DEFAULT_POLL_DIV,
  parameter int HALF_BIT    = DEFAULT_HALF_BIT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [NUM_PADS-1:0]             pad_data,
  output logic                            latch,
  output logic                            pulse,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] press_evt,
  output logic                            scan_done,
  output logic                            overrun
);

  localparam int POLL_W  = width_of(POLL_DIV);
  localparam int PHASE_W = width_of(2 * HALF_BIT);
  localparam int BIT_W   = width_of(NUM_BUTTONS);

  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_DIV - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_BIT - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(NUM_BUTTONS - 1);

  scan_state_t state;
  scan_state_t state_next;

  logic [POLL_W-1:0]  poll_cnt;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;
  logic [BIT_W-1:0]   bit_idx;
  logic [BIT_W-1:0]   bit_next;
  logic               tick;
  logic               sample;

  logic [NUM_PADS*NUM_BUTTONS-1:0] shadow_all;

  assign tick = (poll_cnt == POLL_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      phase   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_idx <= bit_next;
    end
  end

  // bit_idx names the bit that will be sampled at the end of the current
  // pulse pair; bit 0 is taken at the end of the latch window.
  always_comb begin
    state_next = state;
    phase_next = phase + 1'b1;
    bit_next   = bit_idx;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        phase_next = '0;
        bit_next   = '0;
        if (tick && enable) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        if (phase == LATCH_LAST) begin
          sample     = 1'b1;
          phase_next = '0;
          bit_next   = bit_idx + 1'b1;
          state_next = (NUM_BUTTONS > 1) ? PULSE_HI : COMMIT;
        end
      end
      PULSE_HI: begin
        if (phase == HALF_LAST) begin
          phase_next = '0;
          state_next = PULSE_LO;
        end
      end
      PULSE_LO: begin
        if (phase == HALF_LAST) begin
          sample     = 1'b1;
          phase_next = '0;
          if (bit_idx == BIT_LAST) begin
            state_next = COMMIT;
          end else begin
            bit_next   = bit_idx + 1'b1;
            state_next = PULSE_HI;
          end
        end
      end
      COMMIT: begin
        phase_next = '0;
        state_next = IDLE;
      end
      default: begin
        phase_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state
  // register while still coming straight out of flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch     <= 1'b0;
      pulse     <= 1'b0;
      buttons   <= '0;
      press_evt <= '0;
      scan_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      latch     <= (state_next == LATCH);
      pulse     <= (state_next == PULSE_HI);
      scan_done <= (state == COMMIT);
      overrun   <= overrun | (tick && (state != IDLE));
      if (state == COMMIT) begin
        buttons   <= shadow_all;
        press_evt <= shadow_all & ~buttons;
      end else begin
        press_evt <= '0;
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
    gamepad_lane #(
      .NUM_BUTTONS(NUM_BUTTONS),
      .BIT_W      (BIT_W)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .data   (pad_data[p]),
      .sample (sample),
      .bit_idx(bit_idx),
      .shadow (shadow_all[p*NUM_BUTTONS +: NUM_BUTTONS])
    );
  end

endmodule

// File: tb/tb_gamepad_scanner.sv
// Bench for gamepad_scanner: a 4-pad instance behind a scoreboard plus a
// fast-polling 2-pad instance for overrun and enable behaviour.
module tb_gamepad_scanner;

  localparam int NB       = 8;
  localparam int HB       = 4;
  localparam int PADS_A   = 4;
  localparam int PADS_B   = 2;
  localparam int POLL_A   = 2000;
  localparam int POLL_B   = 40;
  localparam int SCAN_LEN = 2*HB + (NB-1)*2*HB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 rst_n_a, enable_a;
  logic [PADS_A-1:0]    pad_a;
  logic                 latch_a, pulse_a, done_a, overrun_a;
  logic [PADS_A*NB-1:0] buttons_a, press_a;

  logic                 rst_n_b, enable_b;
  logic [PADS_B-1:0]    pad_b;
  logic                 latch_b, pulse_b, done_b, overrun_b;
  logic [PADS_B*NB-1:0] buttons_b, press_b;

  gamepad_scanner #(
    .NUM_PADS(PADS_A), .NUM_BUTTONS(NB), .POLL_DIV(POLL_A), .HALF_BIT(HB)
  ) u_dut_a (
    .clk(clk), .reset_n(rst_n_a), .enable(enable_a), .pad_data(pad_a),
    .latch(latch_a), .pulse(pulse_a), .buttons(buttons_a),
    .press_evt(press_a), .scan_done(done_a), .overrun(overrun_a)
  );

  gamepad_scanner #(
    .NUM_PADS(PADS_B), .NUM_BUTTONS(NB), .POLL_DIV(POLL_B), .HALF_BIT(HB)
  ) u_dut_b (
    .clk(clk), .reset_n(rst_n_b), .enable(enable_b), .pad_data(pad_b),
    .latch(latch_b), .pulse(pulse_b), .buttons(buttons_b),
    .press_evt(press_b), .scan_done(done_b), .overrun(overrun_b)
  );

  // Serial pad model: latch reloads bit 0, each pulse rise shifts to the next bit.
  logic [PADS_A-1:0][NB-1:0] pat_a;
  logic [PADS_B-1:0][NB-1:0] pat_b;
  int   idx_a = 0, idx_b = 0;
  logic pulse_a_d = 1'b0, pulse_b_d = 1'b0;

  always @(posedge clk) begin
    if (latch_a) idx_a <= 0;
    else if (pulse_a && !pulse_a_d) idx_a <= idx_a + 1;
    pulse_a_d <= pulse_a;
    if (latch_b) idx_b <= 0;
    else if (pulse_b && !pulse_b_d) idx_b <= idx_b + 1;
    pulse_b_d <= pulse_b;
  end

  always @* begin
    for (int p = 0; p < PADS_A; p++)
      pad_a[p] = (idx_a < NB) ? ~pat_a[p][idx_a[2:0]] : 1'b0;
    for (int p = 0; p < PADS_B; p++)
      pad_b[p] = (idx_b < NB) ? ~pat_b[p][idx_b[2:0]] : 1'b0;
  end

  typedef struct packed {
    logic [PADS_A*NB-1:0] buttons;
    logic [PADS_A*NB-1:0] press;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   stray   = 0;
  logic [PADS_A*NB-1:0] prev_buttons_a = '0;
  logic prev_done_a = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeout_fail(input string name, input int budget);
    vectors++;
    errors++;
    $display("[TB] FAIL %s: no event within %0d cycles, expected one", name, budget);
  endtask

  // Scoreboard monitor: every scan_done pops one expectation; between scans
  // buttons must hold and press_evt must stay clear.
  always @(negedge clk) begin
    if (!rst_n_a) begin
      prev_buttons_a <= buttons_a;
      prev_done_a    <= 1'b0;
    end else begin
      if (done_a) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL unexpected scan_done: buttons 0x%0h, expected no scan", buttons_a);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("scan buttons", buttons_a, e.buttons);
          check_output("scan press_evt", press_a, e.press);
        end
        if (prev_done_a) stray++;
      end else begin
        if (press_a != '0) stray++;
        if (buttons_a != prev_buttons_a) stray++;
      end
      prev_buttons_a <= buttons_a;
      prev_done_a    <= done_a;
    end
  end

  task automatic wait_latch_a(input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!latch_a) begin
      if (n == budget) begin
        ok = 1'b0;
        timeout_fail("A latch start", budget);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!done_a) begin
      if (n == budget) begin
        ok = 1'b0;
        timeout_fail("A scan_done", budget);
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic apply_stimulus_a();
    bit   ok;
    int   n, latch_len, rises, last_rise, gap_bad, hi_run, hi_bad, overlap;
    int   t_prev;
    logic prev_pulse;

    exp_q.push_back('{buttons: 32'h0000_0041, press: 32'h0000_0041});
    exp_q.push_back('{buttons: 32'h0000_0041, press: 32'h0000_0000});
    exp_q.push_back('{buttons: 32'h0000_0041, press: 32'h0000_0000});

    wait_latch_a(POLL_A + 100, ok);
    if (!ok) return;
    n = 0; latch_len = 0; rises = 0; last_rise = 0; gap_bad = 0;
    hi_run = 0; hi_bad = 0; overlap = 0; prev_pulse = 1'b0;
    while (!done_a && n < 200) begin
      if (latch_a) latch_len++;
      if (latch_a && pulse_a) overlap++;
      if (pulse_a && !prev_pulse) begin
        if (n - last_rise != ((rises == 0) ? 2*HB : 2*HB)) gap_bad++;
        last_rise = n;
        rises++;
      end
      if (pulse_a) hi_run++;
      else if (prev_pulse) begin
        if (hi_run != HB) hi_bad++;
        hi_run = 0;
      end
      prev_pulse = pulse_a;
      @(negedge clk);
      n++;
    end
    check_output("latch high cycles", latch_len, 2*HB);
    check_output("pulse count", rises, NB-1);
    check_output("pulse spacing errors", gap_bad, 0);
    check_output("pulse width errors", hi_bad, 0);
    check_output("latch/pulse overlap cycles", overlap, 0);
    check_output("scan length to scan_done", n, SCAN_LEN);
    t_prev = cyc;

    for (int s = 0; s < 2; s++) begin
      wait_done_a(POLL_A + 100, ok);
      if (!ok) return;
      check_output("scan_done period", cyc - t_prev, POLL_A);
      t_prev = cyc;
    end

    pat_a = {8'h00, 8'hFF, 8'h80, 8'h01};
    exp_q.push_back('{buttons: 32'h00FF_8001, press: 32'h00FF_8000});
    wait_done_a(POLL_A + 100, ok);
    if (!ok) return;

    wait_latch_a(POLL_A + 100, ok);
    if (!ok) return;
    rises = 0; n = 0; prev_pulse = 1'b0;
    while (rises < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (pulse_a && !prev_pulse) rises++;
      prev_pulse = pulse_a;
    end
    rst_n_a = 1'b0;
    #1;
    check_output("reset mid-scan latch", latch_a, 0);
    check_output("reset mid-scan pulse", pulse_a, 0);
    check_output("reset mid-scan buttons", buttons_a, 0);
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1;

    exp_q.push_back('{buttons: 32'h00FF_8001, press: 32'h00FF_8001});
    wait_done_a(POLL_A + 100, ok);
    if (!ok) return;
    @(negedge clk);
    check_output("A overrun stays clear", overrun_a, 0);
  endtask

  task automatic apply_stimulus_b();
    int n, rises, dones, ovr_at, done_at, done2_at, second_at;
    logic prev_latch;
    logic [PADS_B*NB-1:0] btn_at_done, press_at_done;

    n = 0;
    while (!latch_b) begin
      if (n == 200) begin
        timeout_fail("B latch start", 200);
        return;
      end
      @(negedge clk);
      n++;
    end
    check_output("B overrun before 2nd tick", overrun_b, 0);
    rises = 0; dones = 0; ovr_at = -1; done_at = -1; done2_at = -1;
    second_at = -1; prev_latch = 1'b1;
    btn_at_done = '0; press_at_done = '0;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (latch_b && !prev_latch) begin
        rises++;
        if (rises == 1) begin
          second_at = i;
          enable_b  = 1'b0;
        end
      end
      if (overrun_b && ovr_at < 0) ovr_at = i;
      if (done_b) begin
        dones++;
        if (dones == 1) begin
          done_at       = i;
          btn_at_done   = buttons_b;
          press_at_done = press_b;
        end
        if (dones == 2) done2_at = i;
      end
      prev_latch = latch_b;
    end
    check_output("B overrun set cycle", ovr_at, 40);
    check_output("B first scan_done cycle", done_at, SCAN_LEN);
    check_output("B buttons", btn_at_done, 16'h0041);
    check_output("B press_evt", press_at_done, 16'h0041);
    check_output("B next scan start cycle", second_at, 80);
    check_output("B scan after disable completes", done2_at, 80 + SCAN_LEN);
    check_output("B latch starts in 240 cycles", rises, 1);
    check_output("B scan_done count", dones, 2);
  endtask

  initial begin
    rst_n_a  = 1'b0;
    rst_n_b  = 1'b0;
    enable_a = 1'b1;
    enable_b = 1'b1;
    pat_a    = {8'h00, 8'h00, 8'h00, 8'h41};
    pat_b    = {8'h00, 8'h41};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset buttons", buttons_a, 0);
    check_output("reset press_evt", press_a, 0);
    check_output("reset latch/pulse", {latch_a, pulse_a}, 0);
    check_output("reset scan_done/overrun", {done_a, overrun_a}, 0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    fork
      apply_stimulus_a();
      apply_stimulus_b();
    join
    repeat (2) @(negedge clk);
    check_output("stray activity outside commit", stray, 0);
    check_output("scoreboard left over", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #400_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
